// File: rtl/pipelined_mult_hs.sv
// Five-stage pipelined WIDTH x WIDTH multiplier with signed/unsigned mode per operation,
// valid/ready handshakes on both sides and a sideband tag carried alongside each operation.
module pipelined_mult_hs #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // The whole pipeline moves as one unit: it advances whenever the output slot is empty
    // or being drained, so in_ready never looks at in_valid and bubbles stay in place.
    logic adv;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    sum;

    logic s1_valid, s2_valid, s3_valid, s4_valid;
    logic s1_sign, s2_sign, s3_sign, s4_sign;
    logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;

    logic [H-1:0]   s1_ah, s1_al, s1_bh, s1_bl;
    logic [2*H-1:0] s2_hh, s2_hl, s2_lh, s2_ll;
    logic [2*H-1:0] s3_hh, s3_ll;
    logic [2*H:0]   s3_mid;
    logic [PW-1:0]  s4_hh, s4_mid, s4_ll;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = s1_valid || s2_valid || s3_valid || s4_valid || out_valid;

    // The most negative operand maps to magnitude 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        sum   = s4_hh + s4_mid + s4_ll;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s4_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            s3_valid  <= s2_valid;
            s4_valid  <= s3_valid;
            out_valid <= s4_valid;
            out_p     <= s4_sign ? -sum : sum;
            out_tag   <= s4_tag;
        end
    end

    // Datapath registers need no reset: their contents only matter alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_sign <= in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_tag  <= in_tag;
            s1_ah   <= mag_a[WIDTH-1:H];
            s1_al   <= mag_a[H-1:0];
            s1_bh   <= mag_b[WIDTH-1:H];
            s1_bl   <= mag_b[H-1:0];

            s2_sign <= s1_sign;
            s2_tag  <= s1_tag;
            s2_hh   <= {{H{1'b0}}, s1_ah} * {{H{1'b0}}, s1_bh};
            s2_hl   <= {{H{1'b0}}, s1_ah} * {{H{1'b0}}, s1_bl};
            s2_lh   <= {{H{1'b0}}, s1_al} * {{H{1'b0}}, s1_bh};
            s2_ll   <= {{H{1'b0}}, s1_al} * {{H{1'b0}}, s1_bl};

            s3_sign <= s2_sign;
            s3_tag  <= s2_tag;
            s3_hh   <= s2_hh;
            s3_ll   <= s2_ll;
            s3_mid  <= {1'b0, s2_hl} + {1'b0, s2_lh};

            s4_sign <= s3_sign;
            s4_tag  <= s3_tag;
            s4_hh   <= {s3_hh, {WIDTH{1'b0}}};
            s4_mid  <= {{(H-1){1'b0}}, s3_mid, {H{1'b0}}};
            s4_ll   <= {{WIDTH{1'b0}}, s3_ll};
        end
    end

endmodule
